// File: rtl/traffic_light_ctrl.sv
// Two-way intersection light sequencer: built-in tick prescaler, NS/EW phase
// timer with pedestrian green truncation, night flashing-yellow mode, countdown.
module traffic_light_ctrl #(
    parameter int DIV         = 100000000,
    parameter int T_GREEN     = 25,
    parameter int T_YELLOW    = 3,
    parameter int T_ALLRED    = 2,
    parameter int T_MIN_GREEN = 5
) (
    input  logic       clk100M,
    input  logic       clr,
    input  logic       en,
    input  logic       night,
    input  logic       ped_req,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic [6:0] countdown,
    output logic       tick,
    output logic       ped_ack
);

    typedef enum logic [2:0] {
        NS_G,
        NS_Y,
        RED1,
        EW_G,
        EW_Y,
        RED2,
        FLASH
    } state_t;

    localparam int             PW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]  PS_LAST  = PW'(DIV - 1);
    localparam logic [6:0]     D_GREEN  = 7'(T_GREEN);
    localparam logic [6:0]     D_YELLOW = 7'(T_YELLOW);
    localparam logic [6:0]     D_ALLRED = 7'(T_ALLRED);
    localparam logic [6:0]     D_MIN    = 7'(T_MIN_GREEN);

    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    function automatic logic [6:0] phase_len(input state_t s);
        case (s)
            NS_G, EW_G: phase_len = D_GREEN;
            NS_Y, EW_Y: phase_len = D_YELLOW;
            default:    phase_len = D_ALLRED;
        endcase
    endfunction

    function automatic state_t phase_after(input state_t s);
        case (s)
            RED2:    phase_after = NS_G;
            NS_G:    phase_after = NS_Y;
            NS_Y:    phase_after = RED1;
            RED1:    phase_after = EW_G;
            EW_G:    phase_after = EW_Y;
            default: phase_after = RED2;
        endcase
    endfunction

    // {ns, ew} lamp pattern for a state; only one direction is ever non-red
    // outside FLASH.
    function automatic logic [5:0] lamp_decode(input state_t s, input logic f);
        case (s)
            NS_G:    lamp_decode = {LAMP_G, LAMP_R};
            NS_Y:    lamp_decode = {LAMP_Y, LAMP_R};
            EW_G:    lamp_decode = {LAMP_R, LAMP_G};
            EW_Y:    lamp_decode = {LAMP_R, LAMP_Y};
            FLASH:   lamp_decode = {1'b0, f, 1'b0, 1'b0, f, 1'b0};
            default: lamp_decode = {LAMP_R, LAMP_R};
        endcase
    endfunction

    logic [PW-1:0] ps_cnt;
    state_t        state, state_nxt;
    logic [6:0]    remain, remain_nxt;
    logic          ped_pend, ped_pend_nxt;
    logic          ped_served, ped_served_nxt;
    logic          flash, flash_nxt;
    logic          ack_nxt;
    logic          step;
    logic          is_green;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk100M) begin
        if (clr) begin
            ps_cnt <= '0;
            tick   <= 1'b0;
        end else if (en) begin
            ps_cnt <= (ps_cnt == PS_LAST) ? '0 : ps_cnt + PW'(1);
            tick   <= (ps_cnt == PS_LAST);
        end else begin
            tick   <= 1'b0;
        end
    end

    assign step     = tick & en;
    assign is_green = (state == NS_G) || (state == EW_G);

    // NOTE: every variable gets a default before any branch so the block
    // stays purely combinational.
    always_comb begin
        state_nxt      = state;
        remain_nxt     = remain;
        ped_pend_nxt   = ped_pend;
        ped_served_nxt = ped_served;
        flash_nxt      = flash;
        ack_nxt        = 1'b0;

        if (night) begin
            state_nxt      = FLASH;
            remain_nxt     = '0;
            ped_pend_nxt   = 1'b0;
            ped_served_nxt = 1'b0;
            if (state != FLASH)
                flash_nxt = 1'b1;
            else if (step)
                flash_nxt = ~flash;
        end else if (state == FLASH) begin
            ped_pend_nxt = 1'b0;
            if (step) begin
                state_nxt  = RED2;
                remain_nxt = D_ALLRED;
                flash_nxt  = 1'b0;
            end
        end else begin
            ped_pend_nxt = ped_pend | ped_req;
            // A request is served at most once per green; later ones wait.
            if (en && is_green && (ped_pend || ped_req) && !ped_served) begin
                ack_nxt        = 1'b1;
                ped_pend_nxt   = 1'b0;
                ped_served_nxt = 1'b1;
                if (remain > D_MIN)
                    remain_nxt = D_MIN;
            end else if (step) begin
                if (remain == 7'd1) begin
                    state_nxt      = phase_after(state);
                    remain_nxt     = phase_len(state_nxt);
                    ped_served_nxt = 1'b0;
                end else begin
                    remain_nxt = remain - 7'd1;
                end
            end
        end
    end

    always_ff @(posedge clk100M) begin
        if (clr) begin
            state      <= RED2;
            remain     <= D_ALLRED;
            ped_pend   <= 1'b0;
            ped_served <= 1'b0;
            flash      <= 1'b0;
            ped_ack    <= 1'b0;
            ns_light   <= LAMP_R;
            ew_light   <= LAMP_R;
        end else begin
            state      <= state_nxt;
            remain     <= remain_nxt;
            ped_pend   <= ped_pend_nxt;
            ped_served <= ped_served_nxt;
            flash      <= flash_nxt;
            ped_ack    <= ack_nxt;
            {ns_light, ew_light} <= lamp_decode(state_nxt, flash_nxt);
        end
    end

    assign countdown = remain;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl with DIV=4, G=6, Y=2, AR=1, MIN=2.
// Edge numbers count rising edges after clr release; outputs sampled 1 unit later.
module tb_traffic_light_ctrl;

    logic       clk100M = 1'b0;
    logic       clr, en, night, ped_req;
    logic [2:0] ns_light, ew_light;
    logic [6:0] countdown;
    logic       tick, ped_ack;

    int n_checks = 0;
    int n_fail   = 0;
    int n_acks   = 0;
    int now_e    = 0;
    bit in_night = 1'b0;

    localparam logic [2:0] R   = 3'b100;
    localparam logic [2:0] Y   = 3'b010;
    localparam logic [2:0] G   = 3'b001;
    localparam logic [2:0] OFF = 3'b000;

    traffic_light_ctrl #(
        .DIV(4), .T_GREEN(6), .T_YELLOW(2), .T_ALLRED(1), .T_MIN_GREEN(2)
    ) dut (
        .clk100M  (clk100M),
        .clr      (clr),
        .en       (en),
        .night    (night),
        .ped_req  (ped_req),
        .ns_light (ns_light),
        .ew_light (ew_light),
        .countdown(countdown),
        .tick     (tick),
        .ped_ack  (ped_ack)
    );

    always #5 clk100M = ~clk100M;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [2:0] ns, input logic [2:0] ew, input int cd);
        check({tag, ".ns"}, 32'(ns_light), 32'(ns));
        check({tag, ".ew"}, 32'(ew_light), 32'(ew));
        check({tag, ".cd"}, 32'(countdown), 32'(cd));
    endtask

    task automatic to_edge(input int n);
        while (now_e < n) begin
            @(posedge clk100M);
            now_e++;
        end
        #1;
    endtask

    // Safety invariant and ack tally, sampled on the falling edge.
    always @(negedge clk100M) begin
        if (ped_ack === 1'b1) n_acks++;
        if (!in_night) begin
            n_checks++;
            assert (ns_light === R || ew_light === R)
            else begin
                n_fail++;
                $error("FAIL safety: observed ns=%b ew=%b expected one red", ns_light, ew_light);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        clr = 1'b1; en = 1'b0; night = 1'b0; ped_req = 1'b0;
        repeat (2) @(posedge clk100M);
        #1;
        // 1. reset and one full cycle
        expect_out("reset", R, R, 1);
        check("reset.tick", 32'(tick), 32'(0));
        check("reset.ack", 32'(ped_ack), 32'(0));
        clr = 1'b0; en = 1'b1; now_e = 0;

        to_edge(3);   check("pre_tick", 32'(tick), 32'(0)); expect_out("red2_hold", R, R, 1);
        to_edge(4);   check("first_tick", 32'(tick), 32'(1));
        to_edge(5);   expect_out("ns_g", G, R, 6); check("tick_low", 32'(tick), 32'(0));
        to_edge(9);   expect_out("ns_g_dec", G, R, 5);
        to_edge(28);  expect_out("ns_g_last", G, R, 1);
        to_edge(29);  expect_out("ns_y", Y, R, 2);
        to_edge(37);  expect_out("red1", R, R, 1);
        to_edge(41);  expect_out("ew_g", R, G, 6);
        to_edge(65);  expect_out("ew_y", R, Y, 2);
        to_edge(73);  expect_out("red2", R, R, 1);
        to_edge(77);  expect_out("ns_g2", G, R, 6);

        // 2. pedestrian truncation in NS_G
        to_edge(81);  expect_out("ped_pre", G, R, 5);
        ped_req = 1'b1;
        to_edge(82);  expect_out("ped_trunc", G, R, 2); check("ped_ack", 32'(ped_ack), 32'(1));
        ped_req = 1'b0;
        to_edge(83);  check("ped_ack_1cyc", 32'(ped_ack), 32'(0));
        to_edge(85);  expect_out("ped_dec", G, R, 1);
        to_edge(89);  expect_out("ped_ns_y", Y, R, 2);

        // 3. request in red held until EW_G; request at MIN green acks only
        to_edge(97);  expect_out("red1_b", R, R, 1);
        ped_req = 1'b1;
        to_edge(98);  check("red_no_ack", 32'(ped_ack), 32'(0));
        ped_req = 1'b0;
        to_edge(101); expect_out("ew_g_entry", R, G, 6); check("entry_no_ack", 32'(ped_ack), 32'(0));
        to_edge(102); expect_out("ew_g_trunc", R, G, 2); check("late_ack", 32'(ped_ack), 32'(1));
        to_edge(103); check("late_ack_1cyc", 32'(ped_ack), 32'(0));
        to_edge(109); expect_out("ew_y_b", R, Y, 2);
        to_edge(121); expect_out("ns_g3", G, R, 6);
        to_edge(137); expect_out("ns_g3_at2", G, R, 2);
        ped_req = 1'b1;
        to_edge(138); expect_out("min_no_trunc", G, R, 2); check("min_ack", 32'(ped_ack), 32'(1));
        ped_req = 1'b0;
        to_edge(139); check("min_ack_1cyc", 32'(ped_ack), 32'(0));
        to_edge(141); expect_out("min_dec", G, R, 1);
        to_edge(145); expect_out("ns_y_c", Y, R, 2);

        // 4. pause mid-EW_G
        to_edge(165); expect_out("pause_pre", R, G, 4);
        en = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            to_edge(165 + i);
            check("pause_tick", 32'(tick), 32'(0));
        end
        expect_out("pause_hold", R, G, 4);
        en = 1'b1;
        to_edge(187); check("resume_no_tick", 32'(tick), 32'(0)); expect_out("resume_hold", R, G, 4);
        to_edge(188); check("resume_tick", 32'(tick), 32'(1));
        to_edge(189); expect_out("resume_dec", R, G, 3);

        // 5. night flashing during NS_G
        to_edge(217); expect_out("night_pre", G, R, 5);
        in_night = 1'b1; night = 1'b1;
        to_edge(218); expect_out("flash_on", Y, Y, 0); check("flash_no_ack", 32'(ped_ack), 32'(0));
        to_edge(220); expect_out("flash_hold", Y, Y, 0); check("flash_tick", 32'(tick), 32'(1));
        to_edge(221); expect_out("flash_off", OFF, OFF, 0);
        to_edge(225); expect_out("flash_on2", Y, Y, 0);
        ped_req = 1'b1;
        to_edge(226); check("flash_ped_ign", 32'(ped_ack), 32'(0));
        ped_req = 1'b0; night = 1'b0;
        to_edge(228); expect_out("flash_wait", Y, Y, 0);
        to_edge(229); expect_out("night_exit", R, R, 1);
        in_night = 1'b0;
        to_edge(233); expect_out("night_ns_g", G, R, 6);
        to_edge(234); expect_out("night_no_trunc", G, R, 6); check("night_no_ack", 32'(ped_ack), 32'(0));

        // 6. clr during EW_Y with a pending request
        to_edge(293); expect_out("ew_y_d", R, Y, 2);
        ped_req = 1'b1;
        to_edge(294); check("ew_y_no_ack", 32'(ped_ack), 32'(0));
        ped_req = 1'b0; clr = 1'b1;
        to_edge(295); expect_out("clr_mid", R, R, 1);
        check("clr_tick", 32'(tick), 32'(0));
        check("clr_ack", 32'(ped_ack), 32'(0));
        clr = 1'b0; now_e = 0;
        to_edge(4);   check("clr_first_tick", 32'(tick), 32'(1));
        to_edge(5);   expect_out("clr_ns_g", G, R, 6);
        to_edge(6);   expect_out("clr_no_trunc", G, R, 6); check("clr_no_ack", 32'(ped_ack), 32'(0));

        @(negedge clk100M);
        #1;
        check("ack_total", 32'(n_acks), 32'(3));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
